// File: rtl/line_mem_responder_pkg.sv
// Shared constants for the line memory responder: state encoding, default line/address widths
// and the optional latency-jitter LFSR (enabled by LINE_MEM_JITTER_EN in the top module).
package line_mem_responder_pkg;

  localparam int unsigned LineWDefault = 128;
  localparam int unsigned AddrWDefault = 28;

  localparam logic [1:0] StateIdle = 2'b00;
  localparam logic [1:0] StateBusy = 2'b01;
  localparam logic [1:0] StateResp = 2'b10;

  typedef enum logic [1:0] {
    StIdle = StateIdle,
    StBusy = StateBusy,
    StResp = StateResp
  } state_e;

  // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
  localparam logic [7:0] LfsrSeed = 8'hA5;
  localparam logic [7:0] LfsrTaps = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LfsrTaps)};
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// Line storage with a preload port and a registered read; storage itself is never reset.
module line_mem_array
  import line_mem_responder_pkg::*;
#(
  parameter int unsigned LINE_W     = LineWDefault,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rd_en_i,
  input  logic [DEPTH_LOG2-1:0] rd_idx_i,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_idx_i,
  input  logic [LINE_W-1:0]     wr_data_i,
  input  logic                  load_en_i,
  input  logic [DEPTH_LOG2-1:0] load_idx_i,
  input  logic [LINE_W-1:0]     load_data_i,
  output logic [LINE_W-1:0]     rd_data_o
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [LINE_W-1:0] mem_q [Depth];
  logic [LINE_W-1:0] rd_data_q;

  // Later assignment wins: a responder write beats a preload to the same index.
  always_ff @(posedge clk_i) begin
    if (load_en_i) begin
      mem_q[load_idx_i] <= load_data_i;
    end
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/line_mem_responder.sv
// Slow line memory behind the cache line interface; fixed latency, optional jitter under
// LINE_MEM_JITTER_EN.
module line_mem_responder
  import line_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W     = AddrWDefault,
  parameter int unsigned LINE_W     = LineWDefault,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  proc_reset_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [LINE_W-1:0]     mem_wdata,
  output logic [LINE_W-1:0]     mem_rdata,
  output logic                  mem_ready,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [LINE_W-1:0]     load_data
);

  localparam int unsigned CntW = 9;
  typedef logic [CntW-1:0] cnt_t;

  state_e                state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]     wdata_q, wdata_d;
  logic                  write_q, write_d;
  cnt_t                  jitter;
  logic                  unused_addr_hi;

  // Upper address bits alias by design.
  assign unused_addr_hi = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

`ifdef LINE_MEM_JITTER_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign jitter = cnt_t'(lfsr_q[1:0]);
`else
  assign jitter = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    case (state_q)
      StIdle: begin
        if (mem_read || mem_write) begin
          addr_d  = mem_addr[DEPTH_LOG2-1:0];
          wdata_d = mem_wdata;
          write_d = mem_write;
          cnt_d   = cnt_t'(LATENCY - 1) + jitter;
          state_d = (cnt_d == '0) ? StResp : StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - cnt_t'(1);
        if (cnt_q == cnt_t'(1)) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  logic rd_en;
  logic wr_en;

  // Read is captured on the edge entering RESP so data is valid for the whole RESP cycle.
  assign rd_en     = (state_d == StResp) && !write_d;
  assign wr_en     = (state_q == StResp) && write_q;
  assign mem_ready = (state_q == StResp);

  line_mem_array #(
    .LINE_W    (LINE_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i      (clk),
    .rst_ni     (proc_reset_n),
    .rd_en_i    (rd_en),
    .rd_idx_i   (addr_d),
    .wr_en_i    (wr_en),
    .wr_idx_i   (addr_q),
    .wr_data_i  (wdata_q),
    .load_en_i  (load_en),
    .load_idx_i (load_addr),
    .load_data_i(load_data),
    .rd_data_o  (mem_rdata)
  );

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder against an array-based reference model.
module tb_line_mem_responder;

  localparam int unsigned Lat = 4;

  logic         clk;
  logic         rst_n;
  logic         rd, wr;
  logic [27:0]  addr;
  logic [127:0] wdata;
  logic [127:0] rdata;
  logic         ready;
  logic         load_en;
  logic [9:0]   load_addr;
  logic [127:0] load_data;

  logic         rd1;
  logic [127:0] unused_rdata1;
  logic         ready1;

  int checks;
  int failures;
  int hist[4];

  logic [127:0] model_mem [1024];
  logic [127:0] last_rdata;

  line_mem_responder #(
    .ADDR_W(28), .LINE_W(128), .DEPTH_LOG2(10), .LATENCY(Lat)
  ) u_dut (
    .clk(clk), .proc_reset_n(rst_n), .mem_read(rd), .mem_write(wr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_rdata(rdata), .mem_ready(ready), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data)
  );

  line_mem_responder #(
    .ADDR_W(28), .LINE_W(128), .DEPTH_LOG2(10), .LATENCY(1)
  ) u_dut1 (
    .clk(clk), .proc_reset_n(rst_n), .mem_read(rd1), .mem_write(1'b0), .mem_addr(28'd0),
    .mem_wdata(128'd0), .mem_rdata(unused_rdata1), .mem_ready(ready1), .load_en(1'b0),
    .load_addr(10'd0), .load_data(128'd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issue one request; returns cycles from the accepting edge to the mem_ready cycle.
  task automatic do_req(input bit is_wr, input bit both, input logic [27:0] a,
                        input logic [127:0] d, input bit collide, input logic [127:0] cdata,
                        output int lat, output logic [127:0] got);
    @(negedge clk);
    rd = !is_wr || both;
    wr = is_wr;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    lat = 1;
    // Scramble the bus after acceptance; the latched transaction must be unaffected.
    addr = $urandom;
    wdata = rand_line();
    while (!ready && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = rdata;
    rd = 1'b0;
    wr = 1'b0;
    if (collide) begin
      load_en = 1'b1;
      load_addr = a[9:0];
      load_data = cdata;
    end
    @(posedge clk);
    #1;
    load_en = 1'b0;
    check128("ready_one_cycle", 128'(ready), 128'(0));
  endtask

  task automatic txn(input string tag, input bit is_wr, input bit both, input logic [27:0] a,
                     input logic [127:0] d, input bit collide, input logic [127:0] cdata);
    int lat;
    logic [127:0] got;
    logic [127:0] exp_rd;
    int idx;
    idx = int'(a[9:0]);
    exp_rd = is_wr ? last_rdata : model_mem[idx];
    do_req(is_wr, both, a, d, collide, cdata, lat, got);
`ifdef LINE_MEM_JITTER_EN
    check128({tag, "_lat_range"}, 128'(lat >= Lat && lat <= Lat + 3), 128'(1));
    if (lat >= Lat && lat <= Lat + 3) hist[lat-Lat]++;
`else
    check128({tag, "_lat"}, 128'(lat), 128'(Lat));
`endif
    check128({tag, "_rdata"}, got, exp_rd);
    last_rdata = exp_rd;
    if (is_wr) model_mem[idx] = d;
    else if (collide) model_mem[idx] = cdata;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 4; i++) hist[i] = 0;
    rst_n = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
    rd1 = 1'b0;
    addr = '0;
    wdata = '0;
    load_en = 1'b0;
    load_addr = '0;
    load_data = '0;
    last_rdata = '0;

    // Preload the whole array while reset is held.
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      load_en = 1'b1;
      load_addr = 10'(i);
      load_data = rand_line();
      model_mem[i] = load_data;
    end
    @(negedge clk);
    load_en = 1'b0;
    check128("reset_ready", 128'(ready), 128'(0));
    check128("reset_rdata", rdata, 128'(0));
    check128("reset_ready_lat1", 128'(ready1), 128'(0));
    rst_n = 1'b1;

    // LATENCY=1 with a request held high: pulse in every other cycle only.
    @(negedge clk);
    rd1 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      check128("lat1_pulse", 128'(ready1), 128'((k % 2) == 0));
    end
    rd1 = 1'b0;

    // Preloaded line read back.
    @(negedge clk);
    load_en = 1'b1;
    load_addr = 10'd5;
    load_data = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    model_mem[5] = load_data;
    @(negedge clk);
    load_en = 1'b0;
    txn("read5", 1'b0, 1'b0, 28'h5, '0, 1'b0, '0);

    // Write then read through an aliasing address.
    txn("wr3ff", 1'b1, 1'b0, 28'h3FF, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_CAFE, 1'b0, '0);
    txn("rd7ff", 1'b0, 1'b0, 28'h7FF, '0, 1'b0, '0);

    // Read and write together count as a write.
    txn("both9", 1'b1, 1'b1, 28'h9, rand_line(), 1'b0, '0);
    txn("rd9", 1'b0, 1'b0, 28'h9, '0, 1'b0, '0);

    // Preload colliding with a RESP write and with a read RESP.
    txn("wr20_coll", 1'b1, 1'b0, 28'd20, rand_line(), 1'b1, rand_line());
    txn("rd20", 1'b0, 1'b0, 28'd20, '0, 1'b0, '0);
    txn("rd21_coll", 1'b0, 1'b0, 28'd21, '0, 1'b1, rand_line());
    txn("rd21", 1'b0, 1'b0, 28'd21, '0, 1'b0, '0);

    // Reset in the middle of a write to line 2.
    @(negedge clk);
    wr = 1'b1;
    addr = 28'h2;
    wdata = rand_line();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check128("midrst_ready", 128'(ready), 128'(0));
    check128("midrst_rdata", rdata, 128'(0));
    wr = 1'b0;
    last_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    txn("rd2_after_rst", 1'b0, 1'b0, 28'h2, '0, 1'b0, '0);

    // Random traffic; reads only when latency jitter is under test.
    for (int n = 0; n < 64; n++) begin
`ifdef LINE_MEM_JITTER_EN
      txn("rand_rd", 1'b0, 1'b0, 28'($urandom), '0, 1'b0, '0);
`else
      txn("rand", 1'($urandom_range(0, 1)), 1'b0, 28'($urandom), rand_line(), 1'b0, '0);
`endif
    end
`ifdef LINE_MEM_JITTER_EN
    for (int i = 0; i < 4; i++) check128("jitter_hist", 128'(hist[i] > 0), 128'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
